byte_div_seq: RTL and testbench
===============================

// Module: byte_div_seq
// PURPOSE
//  Sequential 8-bit restoring divider controller built around one byteSub
//  (8-bit ripple-borrow subtractor, borrow-in tied 0). Runs one trial
//  subtraction per clock over 8 iterations and returns quotient and remainder
//  through a start/busy/done handshake. It is the divide path of the
//  alu_sum_res_mul unit and shares the subtractor datapath style with it.
// PARAMETERS
//  DIVZ_QUOT    8'hFF  quotient returned on divide-by-zero
//  DONE_STICKY  0      0: done is a 1-cycle pulse; 1: done held until next accepted start
// PORTS
//  clk    in   1  single clock, rising edge
//  rst    in   1  synchronous, active-high reset
//  start  in   1  request; sampled only in IDLE
//  a      in   8  dividend, captured on accepted start
//  b      in   8  divisor, captured on accepted start
//  busy   out  1  high from the cycle after accept until done
//  done   out  1  result valid strobe (see DONE_STICKY)
//  q      out  8  quotient, held stable until next accepted start
//  r      out  8  remainder, held stable until next accepted start
//  dz     out  1  divide-by-zero flag, valid with done
// BEHAVIOUR
//  - Reset: state=IDLE; busy=0, done=0, q=0, r=0, dz=0; iteration counter=0.
//  - States: IDLE -> PREP -> RUN(x8) -> FIN -> DONE -> IDLE. DIVZ: PREP -> DONE.
//  - IDLE: start=1 latches a and b and goes to PREP; done clears in the same
//    edge (including the sticky case). start is ignored in all other states.
//  - PREP: if b==0, set q=DIVZ_QUOT, r=a, dz=1 and go to DONE. Otherwise
//    R9=0 (9-bit partial remainder), Q=dividend, cnt=7, dz=0, go to RUN.
//  - RUN (one iteration per clock):
//    {R9,Q} shifts left 1; D = R9[7:0] - B through byteSub.
//    Trial succeeds if shifted R9[8]==1 OR byteSub borrow-out==0.
//    On success, R9={1'b0,D} and Q[0]=1; on failure, R9 is kept and Q[0]=0.
//    cnt decrements; leave for FIN when cnt==0 after this iteration.
//  - FIN: q=Q, r=R9[7:0] (after sign fix in signed mode); go to DONE.
//  - DONE: done=1 for exactly 1 cycle, then IDLE (sticky: done stays 1 in IDLE).
//  - busy=1 in PREP, RUN and FIN; busy=0 in IDLE and DONE.
//  - Latency: done is high in the cycle following the 11th rising edge after
//    the accept edge (accept edge + PREP + 8 RUN + FIN). Divide-by-zero: done
//    is high after the 2nd edge. Back-to-back: a start in the DONE cycle is
//    ignored; the next start is accepted one cycle later, in IDLE.
//  - Boundaries: a<b gives q=0, r=a. b=1 gives q=a, r=0. a=b gives q=1, r=0.
//    No operand wraps outside the 9-bit R9.
//  - rst mid-operation: abort immediately and apply reset values. The
//    partial result is discarded and no done is produced.
// CONFIGURATION
//  BYTE_DIV_SIGNED_EN defined: a and b are two's complement. PREP converts
//    both to magnitude (-128 maps to 8'd128). FIN negates q if a[7]^b[7] and
//    negates r if a[7]. -128/-1 wraps to q=8'h80, r=0, dz=0. Divide-by-zero
//    still returns DIVZ_QUOT and r=a. Latency is unchanged.
//  BYTE_DIV_SIGNED_EN undefined: unsigned only, with no conversion logic.
// TESTING
//  1. a=100, b=7, start pulse -> q=14, r=2, dz=0; done exactly 11 edges after accept.
//  2. a=255, b=1 -> q=255, r=0. Then a=200, b=201 -> q=0, r=200.
//  3. a=5, b=0 -> q=8'hFF, r=5, dz=1; done 2 edges after accept; busy high 1 cycle.
//  4. start held high throughout with a, b changed mid-run -> first result unaffected;
//     next accept occurs only in IDLE, after DONE.
//  5. rst asserted on 4th RUN cycle -> next cycle busy=0, done=0, q=0, r=0;
//     a new start then yields a correct result.
//  6. (SIGNED_EN) a=-100 (8'h9C), b=7 -> q=8'hF2, r=8'hFE. a=8'h80, b=8'hFF ->
//     q=8'h80, r=0. DONE_STICKY=1 -> done stays 1 until the next accept.

Source files
------------

// File: rtl/byte_div_seq_if.sv
// Start/busy/done handshake and operand/result bus for byte_div_seq.
interface byte_div_seq_if;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       busy;
  logic       done;
  logic [7:0] q;
  logic [7:0] r;
  logic       dz;

  modport master (output start, a, b, input busy, done, q, r, dz);
  modport slave  (input start, a, b, output busy, done, q, r, dz);
endinterface

// File: rtl/byte_div_seq.sv
// Sequential 8-bit restoring divider: one ripple-borrow trial subtraction per clock.
// Optional BYTE_DIV_SIGNED_EN: two's complement operands with sign fix-up in PREP/FIN.
module byte_div_seq #(
  parameter logic [7:0] DIVZ_QUOT   = 8'hFF,
  parameter bit         DONE_STICKY = 1'b0
) (
  input logic          clk,
  input logic          rst,
  byte_div_seq_if.slave bus
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PREP = 3'd1;
  localparam logic [2:0] S_RUN  = 3'd2;
  localparam logic [2:0] S_FIN  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  // byteSub: 8-bit ripple-borrow subtractor, borrow-in tied 0; returns {borrow_out, diff}
  function automatic logic [8:0] byte_sub(input logic [7:0] x, input logic [7:0] y);
    logic       bw;
    logic [7:0] d;
    bw = 1'b0;
    d  = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      d[i] = x[i] ^ y[i] ^ bw;
      bw   = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & bw);
    end
    return {bw, d};
  endfunction

  logic [2:0] state_q, state_d;
  logic [7:0] a_q, a_d, b_q, b_d;
  logic [8:0] r9_q, r9_d;
  logic [7:0] quo_q, quo_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] q_q, q_d, r_q, r_d;
  logic       dz_q, dz_d;
  logic       done_q, done_d;

  logic [7:0] mag_a, mag_b, fin_q, fin_r;
  logic [8:0] r9_sh;
  logic [8:0] sub;
  logic       ok;

`ifdef BYTE_DIV_SIGNED_EN
  // -128 negates to 8'h80, which reads correctly as magnitude 128
  assign mag_a = a_q[7] ? (8'd0 - a_q) : a_q;
  assign mag_b = b_q[7] ? (8'd0 - b_q) : b_q;
  assign fin_q = (a_q[7] ^ b_q[7]) ? (8'd0 - quo_q) : quo_q;
  assign fin_r = a_q[7] ? (8'd0 - r9_q[7:0]) : r9_q[7:0];
`else
  assign mag_a = a_q;
  assign mag_b = b_q;
  assign fin_q = quo_q;
  assign fin_r = r9_q[7:0];
`endif

  assign r9_sh = {r9_q[7:0], quo_q[7]};
  assign sub   = byte_sub(r9_sh[7:0], mag_b);
  assign ok    = r9_sh[8] | ~sub[8];

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    r9_d    = r9_q;
    quo_d   = quo_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    r_d     = r_q;
    dz_d    = dz_q;
    done_d  = done_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b;
          done_d  = 1'b0;
          state_d = S_PREP;
        end
      end
      S_PREP: begin
        if (b_q == 8'd0) begin
          q_d     = DIVZ_QUOT;
          r_d     = a_q;
          dz_d    = 1'b1;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          r9_d    = '0;
          quo_d   = mag_a;
          cnt_d   = 3'd7;
          dz_d    = 1'b0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        r9_d  = ok ? {1'b0, sub[7:0]} : r9_sh;
        quo_d = {quo_q[6:0], ok};
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd0) state_d = S_FIN;
      end
      S_FIN: begin
        q_d     = fin_q;
        r_d     = fin_r;
        done_d  = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        if (!DONE_STICKY) done_d = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      r9_q    <= '0;
      quo_q   <= '0;
      cnt_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      dz_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      r9_q    <= r9_d;
      quo_q   <= quo_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dz_q    <= dz_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy = (state_q == S_PREP) || (state_q == S_RUN) || (state_q == S_FIN);
  assign bus.done = done_q;
  assign bus.q    = q_q;
  assign bus.r    = r_q;
  assign bus.dz   = dz_q;

endmodule

// File: tb/tb_byte_div_seq.sv
// Scoreboard bench for byte_div_seq: directed vectors, latency and handshake checks.
module tb_byte_div_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  byte_div_seq_if mif ();
  byte_div_seq_if sif ();

  byte_div_seq #(.DIVZ_QUOT(8'hFF), .DONE_STICKY(1'b0)) dut (
    .clk(clk), .rst(rst), .bus(mif.slave));
  byte_div_seq #(.DIVZ_QUOT(8'hFF), .DONE_STICKY(1'b1)) dut_sticky (
    .clk(clk), .rst(rst), .bus(sif.slave));

  typedef struct {
    logic [7:0] q;
    logic [7:0] r;
    logic       dz;
  } res_t;

  res_t sb[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Monitor: every done pulse of the main DUT must match the oldest expected result
  always @(negedge clk) begin
    if (mif.done) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got q=%0h r=%0h want no result", mif.q, mif.r);
      end else begin
        res_t e;
        e = sb.pop_front();
        chk("q", mif.q, e.q);
        chk("r", mif.r, e.r);
        chk("dz", mif.dz, e.dz);
      end
    end
  end

  task automatic issue(input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] eq, input logic [7:0] er, input logic edz,
                       input bit hold);
    res_t e;
    @(negedge clk);
    mif.a = a;
    mif.b = b;
    mif.start = 1'b1;
    e.q = eq; e.r = er; e.dz = edz;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (!hold) mif.start = 1'b0;
  endtask

  // Called right after the accept edge; the accept edge counts as edge 1
  task automatic wait_done(output int edges, output int busy_n);
    edges = 1;
    busy_n = 0;
    while (1) begin
      @(negedge clk);
      if (mif.done) break;
      if (mif.busy) busy_n++;
      if (edges > 40) begin
        total++;
        bad++;
        $display("FAIL timeout: got no done after %0d edges want done", edges);
        break;
      end
      @(posedge clk);
      edges++;
    end
  endtask

  task automatic run_div(input string nm, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] eq, input logic [7:0] er, input logic edz,
                         input int lat, input int bcyc);
    int e, bn;
    issue(a, b, eq, er, edz, 1'b0);
    wait_done(e, bn);
    chk({nm, "_lat"}, e, lat);
    chk({nm, "_busy"}, bn, bcyc);
  endtask

  initial begin
    int e, bn;
    mif.start = 1'b0; mif.a = '0; mif.b = '0;
    sif.start = 1'b0; sif.a = '0; sif.b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", mif.busy, 0);
    chk("rst_done", mif.done, 0);
    chk("rst_q", mif.q, 0);
    chk("rst_r", mif.r, 0);
    chk("rst_dz", mif.dz, 0);

    run_div("d100_7", 8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 11, 10);
    run_div("d255_1", 8'd255, 8'd1, 8'd255, 8'd0, 1'b0, 11, 10);
`ifdef BYTE_DIV_SIGNED_EN
    run_div("d200_201", 8'd200, 8'd201, 8'd1, 8'hFF, 1'b0, 11, 10);
`else
    run_div("d200_201", 8'd200, 8'd201, 8'd0, 8'd200, 1'b0, 11, 10);
`endif
    run_div("d37_37", 8'd37, 8'd37, 8'd1, 8'd0, 1'b0, 11, 10);
    run_div("d0_9", 8'd0, 8'd9, 8'd0, 8'd0, 1'b0, 11, 10);
    run_div("divz", 8'd5, 8'd0, 8'hFF, 8'd5, 1'b1, 2, 1);
    run_div("d127_2", 8'd127, 8'd2, 8'd63, 8'd1, 1'b0, 11, 10);

    // start held high, operands changed mid-run; DONE-cycle start must be ignored
    issue(8'd50, 8'd6, 8'd8, 8'd2, 1'b0, 1'b1);
    mif.a = 8'd9;
    mif.b = 8'd3;
    begin
      res_t e2;
      e2.q = 8'd3; e2.r = 8'd0; e2.dz = 1'b0;
      sb.push_back(e2);
    end
    wait_done(e, bn);
    chk("hold_lat", e, 11);
    @(posedge clk);
    @(negedge clk);
    chk("hold_idle_busy", mif.busy, 0);
    @(posedge clk);
    @(negedge clk);
    chk("hold_accept_busy", mif.busy, 1);
    mif.start = 1'b0;
    wait_done(e, bn);
    chk("hold2_lat", e, 10);

    // reset during the 4th RUN cycle aborts with no done
    @(negedge clk);
    mif.a = 8'd200; mif.b = 8'd3; mif.start = 1'b1;
    @(posedge clk);
    #1 mif.start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("abort_busy_pre", mif.busy, 1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", mif.busy, 0);
    chk("abort_done", mif.done, 0);
    chk("abort_q", mif.q, 0);
    chk("abort_r", mif.r, 0);
    chk("abort_dz", mif.dz, 0);
    run_div("d77_5", 8'd77, 8'd5, 8'd15, 8'd2, 1'b0, 11, 10);

`ifdef BYTE_DIV_SIGNED_EN
    run_div("s_m100_7", 8'h9C, 8'd7, 8'hF2, 8'hFE, 1'b0, 11, 10);
    run_div("s_m128_m1", 8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, 11, 10);
    run_div("s_divz", 8'hF0, 8'd0, 8'hFF, 8'hF0, 1'b1, 2, 1);
`endif

    // sticky instance: done holds through IDLE until the next accept
    @(negedge clk);
    sif.a = 8'd20; sif.b = 8'd3; sif.start = 1'b1;
    @(posedge clk);
    #1 sif.start = 1'b0;
    e = 1;
    while (!sif.done && e < 40) begin
      @(posedge clk);
      #1 e++;
    end
    chk("st_lat", e, 11);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("st_hold_done", sif.done, 1);
    chk("st_hold_busy", sif.busy, 0);
    chk("st_q", sif.q, 8'd6);
    chk("st_r", sif.r, 8'd2);
    sif.a = 8'd9; sif.b = 8'd2; sif.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    sif.start = 1'b0;
    chk("st_clear_done", sif.done, 0);
    e = 1;
    while (!sif.done && e < 40) begin
      @(posedge clk);
      #1 e++;
    end
    chk("st2_q", sif.q, 8'd4);
    chk("st2_r", sif.r, 8'd1);

    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end
endmodule
